// File: rtl/alu_if.sv
// Operand/result bundle for the single-cycle ALU.
// The ovf signal only exists when ALU_OVERFLOW_EN is defined.
interface alu_if #(
  parameter int WIDTH = 32
);

  logic [4:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] out;
  logic             zero;
`ifdef ALU_OVERFLOW_EN
  logic             ovf;
`endif

`ifdef ALU_OVERFLOW_EN
  modport master (
    output op, A, B,
    input  out, zero, ovf
  );

  modport slave (
    input  op, A, B,
    output out, zero, ovf
  );
`else
  modport master (
    output op, A, B,
    input  out, zero
  );

  modport slave (
    input  op, A, B,
    output out, zero
  );
`endif

endinterface : alu_if

// File: rtl/alu.sv
// Single-cycle registered ALU: out/zero load f(op,A,B) on every rising edge.
// Define ALU_OVERFLOW_EN to add the registered signed-overflow flag ovf.
module alu #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  alu_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_ADDU = 5'b00001,
    OP_SUB  = 5'b00010,
    OP_SUBU = 5'b00011,
    OP_AND  = 5'b00100,
    OP_OR   = 5'b00101,
    OP_XOR  = 5'b00110,
    OP_NOR  = 5'b00111,
    OP_SLT  = 5'b01000,
    OP_SLTU = 5'b01001,
    OP_SLL  = 5'b01010,
    OP_SRA  = 5'b01011,
    OP_SRL  = 5'b01100,
    OP_EQ   = 5'b01101,
    OP_NE   = 5'b01110
  } op_e;

  op_e              op_sel;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic             lt_signed;
  logic             lt_unsigned;
  logic             equal;
  logic [WIDTH-1:0] result;

  assign op_sel = op_e'(bus.op);

  // Signed and unsigned add/sub share one adder; carry/borrow is dropped.
  assign sum   = bus.A + bus.B;
  assign diff  = bus.A - bus.B;
  assign shamt = bus.B[SHW-1:0];

  assign lt_signed   = $signed(bus.A) < $signed(bus.B);
  assign lt_unsigned = bus.A < bus.B;
  assign equal       = bus.A == bus.B;

  always_comb begin
    // NOTE: defaulting every combinational output first means no path can leave it unassigned, so no latch is inferred.
    result = '0;
    unique case (op_sel)
      OP_ADD, OP_ADDU: result = sum;
      OP_SUB, OP_SUBU: result = diff;
      OP_AND:          result = bus.A & bus.B;
      OP_OR:           result = bus.A | bus.B;
      OP_XOR:          result = bus.A ^ bus.B;
      OP_NOR:          result = ~(bus.A | bus.B);
      OP_SLT:          result = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLTU:         result = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_SLL:          result = bus.A << shamt;
      OP_SRA:          result = $unsigned($signed(bus.A) >>> shamt);
      OP_SRL:          result = bus.A >> shamt;
      OP_EQ:           result = {{(WIDTH-1){1'b0}}, equal};
      OP_NE:           result = {{(WIDTH-1){1'b0}}, ~equal};
      default:         result = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  logic add_ovf;
  logic sub_ovf;
  logic ovf_next;

  // Only the signed ops report overflow; the unsigned variants always clear it.
  assign add_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1]  != bus.A[WIDTH-1]);
  assign sub_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);

  always_comb begin
    ovf_next = 1'b0;
    if (op_sel == OP_ADD)      ovf_next = add_ovf;
    else if (op_sel == OP_SUB) ovf_next = sub_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.ovf <= 1'b0;
    else        bus.ovf <= ovf_next;
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out  <= '0;
      bus.zero <= 1'b1;
    end else begin
      bus.out  <= result;
      bus.zero <= (result == '0);
    end
  end

endmodule : alu

// File: tb/tb_alu.sv
// Directed, table-driven bench for alu plus hand-written reset/latency sequences.
module tb_alu;

  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;

  alu_if #(.WIDTH(WIDTH)) bus ();

  alu #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_zero;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];
  int   n_total;
  int   n_passed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check_outputs(input string name, input logic [31:0] exp_out,
                               input logic exp_zero, input logic exp_ovf);
    check({name, ".out"}, bus.out, exp_out);
    check({name, ".zero"}, {31'd0, bus.zero}, {31'd0, exp_zero});
`ifdef ALU_OVERFLOW_EN
    check({name, ".ovf"}, {31'd0, bus.ovf}, {31'd0, exp_ovf});
`else
    if (exp_ovf) begin end
`endif
  endtask

  function automatic vec_t mk(input string name, input logic [4:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp_out,
                              input logic exp_zero, input logic exp_ovf);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b;
    v.exp_out = exp_out; v.exp_zero = exp_zero; v.exp_ovf = exp_ovf;
    return v;
  endfunction

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op = op;
    bus.A  = a;
    bus.B  = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total  = 0;
    n_passed = 0;

    vecs.push_back(mk("add_basic",   5'b00000, 32'd108,        32'd62,         32'd170,        1'b0, 1'b0));
    vecs.push_back(mk("add_ovf",     5'b00000, 32'h7FFFFFFF,   32'h70000001,   32'hF0000000,   1'b0, 1'b1));
    vecs.push_back(mk("addu_wrap",   5'b00001, 32'hFFFFFFFF,   32'h00000001,   32'h00000000,   1'b1, 1'b0));
    vecs.push_back(mk("addu_noovf",  5'b00001, 32'h7FFFFFFF,   32'h00000001,   32'h80000000,   1'b0, 1'b0));
    vecs.push_back(mk("sub_basic",   5'b00010, 32'h0000006C,   32'h0000003E,   32'h0000002E,   1'b0, 1'b0));
    vecs.push_back(mk("sub_swap",    5'b00010, 32'h0000003E,   32'h0000006C,   32'hFFFFFFD2,   1'b0, 1'b0));
    vecs.push_back(mk("sub_ovf",     5'b00010, 32'h80000000,   32'h00000001,   32'h7FFFFFFF,   1'b0, 1'b1));
    vecs.push_back(mk("subu_basic",  5'b00011, 32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFE,   1'b0, 1'b0));
    vecs.push_back(mk("subu_noovf",  5'b00011, 32'h80000000,   32'h00000001,   32'h7FFFFFFF,   1'b0, 1'b0));
    vecs.push_back(mk("and_zero",    5'b00100, 32'h7FFFFFFF,   32'h00000000,   32'h00000000,   1'b1, 1'b0));
    vecs.push_back(mk("or",          5'b00101, 32'h7FFFFFFF,   32'hF0000001,   32'hFFFFFFFF,   1'b0, 1'b0));
    vecs.push_back(mk("xor",         5'b00110, 32'hA0000000,   32'h50000000,   32'hF0000000,   1'b0, 1'b0));
    vecs.push_back(mk("nor",         5'b00111, 32'hA0000000,   32'h50000000,   32'h0FFFFFFF,   1'b0, 1'b0));
    vecs.push_back(mk("slt_true",    5'b01000, 32'hF0000001,   32'hFFFFFFC2,   32'h00000001,   1'b0, 1'b0));
    vecs.push_back(mk("slt_false",   5'b01000, 32'hFFFFFFC2,   32'hFFFFFF94,   32'h00000000,   1'b1, 1'b0));
    vecs.push_back(mk("sltu_true",   5'b01001, 32'h7FFFFFFF,   32'hF0000001,   32'h00000001,   1'b0, 1'b0));
    vecs.push_back(mk("sltu_false",  5'b01001, 32'hF0000001,   32'h7FFFFFFF,   32'h00000000,   1'b1, 1'b0));
    vecs.push_back(mk("eq_true",     5'b01101, 32'h7234ABCC,   32'h7234ABCC,   32'h00000001,   1'b0, 1'b0));
    vecs.push_back(mk("ne_false",    5'b01110, 32'h7234ABCC,   32'h7234ABCC,   32'h00000000,   1'b1, 1'b0));
    vecs.push_back(mk("ne_true",     5'b01110, 32'h00000001,   32'h00000002,   32'h00000001,   1'b0, 1'b0));
    vecs.push_back(mk("sll_16",      5'b01010, 32'h7234ABCC,   32'h00000010,   32'hABCC0000,   1'b0, 1'b0));
    vecs.push_back(mk("sll_hibits",  5'b01010, 32'h7234ABCC,   32'hFFFFFFE1,   32'hE4695798,   1'b0, 1'b0));
    vecs.push_back(mk("sra_9",       5'b01011, 32'hF1A2C371,   32'h00000009,   32'hFFF8D161,   1'b0, 1'b0));
    vecs.push_back(mk("srl_9",       5'b01100, 32'hF1A2C371,   32'h00000009,   32'h0078D161,   1'b0, 1'b0));
    vecs.push_back(mk("sra_32",      5'b01011, 32'hF0001231,   32'h00000020,   32'hF0001231,   1'b0, 1'b0));
    vecs.push_back(mk("srl_31",      5'b01100, 32'h80000000,   32'h0000001F,   32'h00000001,   1'b0, 1'b0));
    vecs.push_back(mk("unused_0f",   5'b01111, 32'h00000005,   32'h00000003,   32'h00000000,   1'b1, 1'b0));
    vecs.push_back(mk("unused_1f",   5'b11111, 32'hFFFFFFFF,   32'h00000001,   32'h00000000,   1'b1, 1'b0));

    // Reset held with active stimulus: outputs must stay at their reset values.
    rst_n = 1'b0;
    drive(5'b00000, 32'h7FFFFFFF, 32'h70000001);
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset_hold", 32'h0, 1'b1, 1'b0);

    // First result appears on the first rising edge after release.
    @(negedge clk);
    rst_n = 1'b1;
    drive(5'b00000, 32'd2, 32'd3);
    @(posedge clk);
    #1;
    check_outputs("first_result", 32'd5, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clk);
      #1;
      check_outputs(vecs[i].name, vecs[i].exp_out, vecs[i].exp_zero, vecs[i].exp_ovf);
    end

    // Output is registered: new operands must not show before the next edge.
    @(negedge clk);
    drive(5'b00000, 32'd108, 32'd62);
    @(posedge clk);
    #1;
    check("latency_load", bus.out, 32'd170);
    @(negedge clk);
    drive(5'b00001, 32'd1, 32'd1);
    #1;
    check("latency_hold", bus.out, 32'd170);
    @(posedge clk);
    #1;
    check("latency_next", bus.out, 32'd2);

    // Asynchronous reset between edges discards the pending result at once.
    @(negedge clk);
    drive(5'b00000, 32'h7FFFFFFF, 32'h70000001);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 32'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check_outputs("async_reset_edge", 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("post_reset_add_ovf", 32'hF0000000, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule : tb_alu
